// File: rtl/lock_level_driver.sv
// lock_level_driver: ramps the canal lock chamber level toward a commanded
// target at one unit every STEP_CYCLES clocks, then pulses done on arrival.
module lock_level_driver #(
    parameter int MAX_LEVEL   = 50,
    parameter int STEP_CYCLES = 4,
    parameter int RESET_LEVEL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_target,
    input  logic       halt,
    output logic [5:0] water_level,
    output logic       moving,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Counter is at least one bit wide so STEP_CYCLES == 1 still elaborates.
    localparam int              CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [5:0]      MAX_L     = 6'(MAX_LEVEL);
    localparam logic [5:0]      RESET_L   = 6'(RESET_LEVEL);

    state_t           state, state_d;
    logic [5:0]       level, level_d;
    logic [5:0]       tgt, tgt_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             done_q, done_d;
    logic             accept;
    logic [5:0]       clamped_target;

    assign cmd_ready      = (state == IDLE) && !halt;
    assign accept         = cmd_valid && cmd_ready;
    assign clamped_target = (cmd_target > MAX_L) ? MAX_L : cmd_target;
    assign moving         = (state != IDLE);
    assign water_level    = level;
    assign done           = done_q;

    // State register: async reset aborts any move and suppresses done.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            level  <= RESET_L;
            tgt    <= RESET_L;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            level  <= level_d;
            tgt    <= tgt_d;
            cnt    <= cnt_d;
            done_q <= done_d;
        end
    end

    // Next-state logic: accept commands, pace steps, detect arrival or halt.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        level_d = level;
        tgt_d   = tgt;
        cnt_d   = cnt;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    tgt_d = clamped_target;
                    cnt_d = '0;
                    if (clamped_target > level) begin
                        state_d = FILL;
                    end else if (clamped_target < level) begin
                        state_d = DRAIN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            FILL, DRAIN: begin
                if (halt) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    // Saturating guards keep the level inside 0..MAX_LEVEL
                    // even if the target register were somehow out of range.
                    if (state == FILL) begin
                        if (level < MAX_L) begin
                            level_d = level + 6'd1;
                        end
                    end else begin
                        if (level != 6'd0) begin
                            level_d = level - 6'd1;
                        end
                    end
                    if (level_d == tgt) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lock_level_driver.sv
// tb_lock_level_driver: directed checks of fill, drain, clamping, equal
// target, halt and asynchronous reset for lock_level_driver.
module tb_lock_level_driver;

    localparam int MAX_LEVEL   = 50;
    localparam int STEP_CYCLES = 4;
    localparam int RESET_LEVEL = 0;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [5:0] cmd_target;
    logic       halt;
    logic [5:0] water_level;
    logic       moving;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    lock_level_driver #(
        .MAX_LEVEL  (MAX_LEVEL),
        .STEP_CYCLES(STEP_CYCLES),
        .RESET_LEVEL(RESET_LEVEL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .halt       (halt),
        .water_level(water_level),
        .moving     (moving),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a command from IDLE and follow it to done. poke >= 0 pulses a
    // stray cmd_valid at that edge index to prove it is ignored mid-move.
    task automatic run_move(input string tag, input logic [5:0] target,
                            input logic [5:0] exp_final, input int exp_edges, input int poke);
        logic [5:0] start;
        logic [5:0] l_before;
        logic [5:0] l_first;
        logic [5:0] exp_first;
        int         edges;
        bit         bad;
        start     = water_level;
        exp_first = (exp_final > start) ? start + 6'd1 : start - 6'd1;
        l_before  = '0;
        l_first   = '0;
        edges     = 0;
        bad       = 1'b0;
        cmd_valid  = 1'b1;
        cmd_target = target;
        step();
        cmd_valid  = 1'b0;
        check({tag, " moving after accept"}, moving, 1);
        while (!done && edges < exp_edges + 20) begin
            if (edges == poke) begin
                cmd_valid  = 1'b1;
                cmd_target = 6'd60;
            end
            step();
            cmd_valid = 1'b0;
            edges++;
            if (edges == STEP_CYCLES - 1) l_before = water_level;
            if (edges == STEP_CYCLES)     l_first  = water_level;
            if (water_level > 6'(MAX_LEVEL)) bad = 1'b1;
            if (!done && (!moving || cmd_ready)) bad = 1'b1;
        end
        check({tag, " edges to done"}, edges, exp_edges);
        check({tag, " final level"}, water_level, exp_final);
        check({tag, " level before first step"}, l_before, start);
        check({tag, " level after first step"}, l_first, exp_first);
        check({tag, " moving at done"}, moving, 0);
        check({tag, " ready at done"}, cmd_ready, 1);
        check({tag, " in-range and busy during move"}, bad, 0);
        step();
        check({tag, " done one cycle"}, done, 0);
        check({tag, " level held"}, water_level, exp_final);
    endtask

    initial begin
        int  guard;
        bit  saw_done;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        halt       = 1'b0;

        // 1. Reset state, then held after release.
        step();
        step();
        check("reset level", water_level, RESET_LEVEL);
        check("reset ready", cmd_ready, 1);
        check("reset moving", moving, 0);
        check("reset done", done, 0);
        reset = 1'b0;
        step();
        step();
        check("post-reset level", water_level, RESET_LEVEL);
        check("post-reset ready", cmd_ready, 1);
        check("post-reset moving", moving, 0);
        check("post-reset done", done, 0);

        // 2. Fill 0 -> 48: 48 * 4 = 192 edges.
        run_move("fill48", 6'd48, 6'd48, 192, -1);

        // 3. Drain 48 -> 2: 46 * 4 = 184 edges, stray cmd_valid at edge 50.
        run_move("drain2", 6'd2, 6'd2, 184, 50);

        // 4. Bring to 40 (38 * 4 = 152), then 63 clamps to 50 (10 * 4 = 40).
        run_move("fill40", 6'd40, 6'd40, 152, -1);
        run_move("clamp63", 6'd63, 6'd50, 40, -1);

        // Equal target: no movement, done on the cycle after accept.
        cmd_valid  = 1'b1;
        cmd_target = 6'd50;
        step();
        cmd_valid  = 1'b0;
        check("equal done", done, 1);
        check("equal moving", moving, 0);
        check("equal level", water_level, 50);
        step();
        check("equal done one cycle", done, 0);

        // 5. Restart from 0, fill toward 30, halt at 20.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset2 level", water_level, RESET_LEVEL);
        cmd_valid  = 1'b1;
        cmd_target = 6'd30;
        step();
        cmd_valid  = 1'b0;
        guard    = 0;
        saw_done = 1'b0;
        while (water_level != 6'd20 && guard < 200) begin
            step();
            guard++;
            if (done) saw_done = 1'b1;
        end
        check("halt reached 20", water_level, 20);
        halt = 1'b1;
        step();
        check("halt moving", moving, 0);
        check("halt level", water_level, 20);
        check("halt done", done, 0);
        cmd_valid  = 1'b1;
        cmd_target = 6'd5;
        check("halt+valid ready", cmd_ready, 0);
        step();
        cmd_valid = 1'b0;
        check("halt+valid not accepted", moving, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("halt level frozen", water_level, 20);
        check("halt no done", saw_done, 0);
        halt = 1'b0;
        step();

        // 6. Fill to 40, drain toward 10, async reset at level 25 between edges.
        run_move("fill40b", 6'd40, 6'd40, 80, -1);
        cmd_valid  = 1'b1;
        cmd_target = 6'd10;
        step();
        cmd_valid  = 1'b0;
        guard = 0;
        while (water_level != 6'd25 && guard < 200) begin
            step();
            guard++;
        end
        check("drain reached 25", water_level, 25);
        #2;
        reset = 1'b1;
        #1;
        check("async reset level", water_level, RESET_LEVEL);
        check("async reset moving", moving, 0);
        check("async reset done", done, 0);
        step();
        check("reset hold done", done, 0);
        reset = 1'b0;
        step();
        check("after reset level", water_level, RESET_LEVEL);
        run_move("post-reset fill3", 6'd3, 6'd3, 12, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
